// File: rtl/cray_addr_pkg.sv
// Shared types and sizes for the X-MP address multiply issue/writeback path.
package cray_addr_pkg;

    localparam int A_W     = 24;
    localparam int A_IDX_W = 3;
    localparam int NUM_A   = 8;

    typedef struct packed {
        logic               valid;
        logic [A_IDX_W-1:0] dest;
    } addr_tag_t;

endpackage

// File: rtl/addr_mult_sequencer_if.sv
// Issue, multiplier and writeback signals of the address multiply sequencer.
interface addr_mult_sequencer_if;
    import cray_addr_pkg::*;

    logic               i_issue_valid;
    logic               o_issue_ready;
    logic [A_IDX_W-1:0] i_i;
    logic [A_IDX_W-1:0] i_j;
    logic [A_IDX_W-1:0] i_k;
    logic [A_W-1:0]     i_aj;
    logic [A_W-1:0]     i_ak;
    logic [A_W-1:0]     o_aj;
    logic [A_W-1:0]     o_ak;
    logic [A_W-1:0]     i_product;
    logic               i_flush;
    logic               o_wb_valid;
    logic [A_IDX_W-1:0] o_wb_addr;
    logic [A_W-1:0]     o_wb_data;
    logic [NUM_A-1:0]   o_a_busy;
    logic [2:0]         o_inflight;

    modport slave (
        input  i_issue_valid, i_i, i_j, i_k, i_aj, i_ak, i_product, i_flush,
        output o_issue_ready, o_aj, o_ak, o_wb_valid, o_wb_addr, o_wb_data,
               o_a_busy, o_inflight
    );

    modport master (
        output i_issue_valid, i_i, i_j, i_k, i_aj, i_ak, i_product, i_flush,
        input  o_issue_ready, o_aj, o_ak, o_wb_valid, o_wb_addr, o_wb_data,
               o_a_busy, o_inflight
    );

endinterface

// File: rtl/addr_tag_pipe.sv
// Destination-tag delay line matching the address multiplier latency.
module addr_tag_pipe
    import cray_addr_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      i_flush,
    input  addr_tag_t i_tag,
    output addr_tag_t o_tag
);

    addr_tag_t r_stage [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < DEPTH; n++) r_stage[n] <= '0;
        end else if (i_flush) begin
            for (int n = 0; n < DEPTH; n++) r_stage[n] <= '0;
        end else begin
            r_stage[0] <= i_tag;
            for (int n = 1; n < DEPTH; n++) r_stage[n] <= r_stage[n-1];
        end
    end

    assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/addr_mult_sequencer.sv
// Issue/writeback sequencer for the 24-bit address multiplier: scoreboard,
// tag tracking across the fixed multiplier latency, registered writeback.
module addr_mult_sequencer
    import cray_addr_pkg::*;
#(
    parameter int MULT_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    addr_mult_sequencer_if.slave  bus
);

    addr_tag_t          w_tag_in;
    addr_tag_t          w_tag_out;
    logic               w_fire;
    logic [NUM_A-1:0]   w_busy_nxt;
    logic [NUM_A-1:0]   r_busy;
    logic               r_wb_valid;
    logic [A_IDX_W-1:0] r_wb_addr;
    logic [A_W-1:0]     r_wb_data;
    logic [2:0]         r_inflight;

    assign bus.o_issue_ready = !bus.i_flush && !r_busy[bus.i_i]
                               && !r_busy[bus.i_j] && !r_busy[bus.i_k];
    assign w_fire   = bus.i_issue_valid && bus.o_issue_ready;
    assign bus.o_aj = w_fire ? bus.i_aj : '0;
    assign bus.o_ak = w_fire ? bus.i_ak : '0;
    assign w_tag_in = '{valid: w_fire, dest: bus.i_i};

    addr_tag_pipe #(.DEPTH(MULT_LAT)) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_flush (bus.i_flush),
        .i_tag   (w_tag_in),
        .o_tag   (w_tag_out)
    );

    // Reservation drops at the end of the writeback cycle, so a dependent
    // instruction reads the A file only after the product has landed.
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_wb_valid) w_busy_nxt[r_wb_addr] = 1'b0;
        if (w_fire)     w_busy_nxt[bus.i_i]   = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_valid <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_data  <= '0;
            r_busy     <= '0;
            r_inflight <= '0;
        end else if (bus.i_flush) begin
            r_wb_valid <= 1'b0;
            r_busy     <= '0;
            r_inflight <= '0;
        end else begin
            r_wb_valid <= w_tag_out.valid;
            if (w_tag_out.valid) begin
                r_wb_addr <= w_tag_out.dest;
                r_wb_data <= bus.i_product;
            end
            r_busy     <= w_busy_nxt;
            r_inflight <= r_inflight + 3'(w_fire) - 3'(r_wb_valid);
        end
    end

    assign bus.o_wb_valid = r_wb_valid;
    assign bus.o_wb_addr  = r_wb_addr;
    assign bus.o_wb_data  = r_wb_data;
    assign bus.o_a_busy   = r_busy;
    assign bus.o_inflight = r_inflight;

endmodule
